// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and helpers for the MIPS hazard controller.
// Holds Tuse/Tnew encodings, MDU state codes and latency defaults.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [4:0] REG_ZERO  = 5'd0;

  localparam logic MDU_IDLE = 1'b0;
  localparam logic MDU_BUSY = 1'b1;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  // A producer blocks a consumer if its result arrives later than needed
  function automatic logic hz_hit(
    input logic [4:0] src,
    input logic [4:0] dst,
    input logic [1:0] tnew,
    input logic [1:0] tuse
  );
    return (src != REG_ZERO) && (src == dst) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
// master = pipeline datapath, slave = hazard controller.
interface pipe_hazard_ctrl_if;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_tuse_rs;
  logic [1:0] D_tuse_rt;
  logic       D_md_use;
  logic [4:0] E_A3;
  logic [1:0] E_tnew;
  logic       E_md_start;
  logic       E_md_is_div;
  logic [4:0] M_A3;
  logic [1:0] M_tnew;
  logic       stall;
  logic       F_en;
  logic       D_en;
  logic       E_clr;
  logic       md_busy;
  logic       md_done;

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_md_use,
    output E_A3, E_tnew, E_md_start, E_md_is_div,
    output M_A3, M_tnew,
    input  stall, F_en, D_en, E_clr, md_busy, md_done
  );

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_md_use,
    input  E_A3, E_tnew, E_md_start, E_md_is_div,
    input  M_A3, M_tnew,
    output stall, F_en, D_en, E_clr, md_busy, md_done
  );
endinterface

// File: rtl/pipe_hazard_ctrl_mdu_seq.sv
// MDU busy sequencer: IDLE/BUSY FSM with a down-counter.
// md_done marks the last busy cycle; starts while busy are ignored.
module mdu_seq
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  input  logic is_div,
  output logic md_busy,
  output logic md_done
);

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_done = 1'b0;
    unique case (1'b1)
      (state_q == MDU_IDLE): begin
        if (start) begin
          state_d = MDU_BUSY;
          cnt_d   = is_div ? CNT_W'(DIV_CYC - 1)
                           : CNT_W'(MULT_CYC - 1);
        end
      end
      default: begin
        if (cnt_q == '0) begin
          md_done = 1'b1;
          state_d = MDU_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  assign md_busy = (state_q == MDU_BUSY);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Tuse/Tnew stall controller and MDU sequencing for the 5-stage MIPS pipe.
// Optional HAZARD_PERF_CNT_EN adds stall_cnt / md_stall_cnt outputs.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 4
) (
  input  logic              Clk,
  input  logic              Reset,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       md_stall_cnt,
`endif
  pipe_hazard_ctrl_if.slave hz
);

  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall_w;
  logic busy_w;
  logic done_w;

  mdu_seq #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_mdu (
    .Clk     (Clk),
    .Reset   (Reset),
    .start   (hz.E_md_start),
    .is_div  (hz.E_md_is_div),
    .md_busy (busy_w),
    .md_done (done_w)
  );

  always_comb begin
    stall_rs = (hz.D_tuse_rs != TUSE_NONE) &&
      (hz_hit(hz.D_rs, hz.E_A3, hz.E_tnew, hz.D_tuse_rs) ||
       hz_hit(hz.D_rs, hz.M_A3, hz.M_tnew, hz.D_tuse_rs));
    stall_rt = (hz.D_tuse_rt != TUSE_NONE) &&
      (hz_hit(hz.D_rt, hz.E_A3, hz.E_tnew, hz.D_tuse_rt) ||
       hz_hit(hz.D_rt, hz.M_A3, hz.M_tnew, hz.D_tuse_rt));
    stall_md = hz.D_md_use && (busy_w || hz.E_md_start);
    stall_w  = stall_rs | stall_rt | stall_md;
  end

  assign hz.stall   = stall_w;
  assign hz.F_en    = ~stall_w;
  assign hz.D_en    = ~stall_w;
  assign hz.E_clr   = stall_w;
  assign hz.md_busy = busy_w;
  assign hz.md_done = done_w;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

  always_comb begin
    stall_cnt_d    = stall_cnt_q + {31'd0, stall_w};
    md_stall_cnt_d = md_stall_cnt_q + {31'd0, stall_md};
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      md_stall_cnt_q <= md_stall_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule
